// File: rtl/reg_wb_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package reg_wb_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_COUNT  = 32;
  localparam int unsigned STARVE_W   = 4;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_ALU  = 2'd1,
    GNT_LD   = 2'd2
  } grant_t;

  function automatic logic is_zero_reg(input logic [REG_ADDR_W-1:0] addr);
    return addr == ZERO_REG;
  endfunction

endpackage

// File: rtl/reg_wb_scoreboard.sv
// Outstanding-load scoreboard: one pending bit per architectural register,
// with three combinational lookup ports (two read ports plus the ALU destination).
module reg_wb_scoreboard
  import reg_wb_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  set_en_i,
  input  logic [REG_ADDR_W-1:0] set_addr_i,
  input  logic                  clr_en_i,
  input  logic [REG_ADDR_W-1:0] clr_addr_i,
  input  logic [REG_ADDR_W-1:0] look_a_i,
  input  logic [REG_ADDR_W-1:0] look_b_i,
  input  logic [REG_ADDR_W-1:0] look_c_i,
  output logic                  pend_a_c_o,
  output logic                  pend_b_c_o,
  output logic                  pend_c_c_o
);

  logic [REG_COUNT-1:0] pending_q;
  logic [REG_COUNT-1:0] pending_d;

  // Clear first so a same-cycle issue to the returning register stays pending.
  always_comb begin
    pending_d = pending_q;
    if (clr_en_i && !is_zero_reg(clr_addr_i)) begin
      pending_d[clr_addr_i] = 1'b0;
    end
    if (set_en_i && !is_zero_reg(set_addr_i)) begin
      pending_d[set_addr_i] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign pend_a_c_o = pending_q[look_a_i];
  assign pend_b_c_o = pending_q[look_b_i];
  assign pend_c_c_o = pending_q[look_c_i];

endmodule

// File: rtl/reg_wb_arbiter.sv
// Arbitrates the single register-file write port between ALU and load
// writebacks, with load starvation bound and WAW ordering against pending loads.
module reg_wb_arbiter
  import reg_wb_pkg::*;
#(
  parameter int unsigned MAX_WAIT   = 3,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_addr,
  input  logic [DATA_WIDTH-1:0] alu_data,
  output logic                  alu_ready,
  input  logic                  ld_issue,
  input  logic [REG_ADDR_W-1:0] ld_issue_addr,
  input  logic                  ld_valid,
  input  logic [REG_ADDR_W-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_data,
  output logic                  ld_ready,
  input  logic [REG_ADDR_W-1:0] rd_addr_a,
  input  logic [REG_ADDR_W-1:0] rd_addr_b,
  output logic                  hazard_a,
  output logic                  hazard_b,
  output logic                  rf_write,
  output logic [REG_ADDR_W-1:0] rf_write_addr,
  output logic [DATA_WIDTH-1:0] rf_data_in
);

  localparam logic [STARVE_W-1:0] MAX_WAIT_C = STARVE_W'(MAX_WAIT);

  grant_t                grant_c;
  logic                  alu_blocked_c;
  logic                  pend_a_c;
  logic                  pend_b_c;
  logic                  pend_alu_c;

  logic [STARVE_W-1:0]   starve_cnt_q;
  logic [STARVE_W-1:0]   starve_cnt_d;
  logic                  rf_write_q;
  logic                  rf_write_d;
  logic [REG_ADDR_W-1:0] rf_write_addr_q;
  logic [REG_ADDR_W-1:0] rf_write_addr_d;
  logic [DATA_WIDTH-1:0] rf_data_in_q;
  logic [DATA_WIDTH-1:0] rf_data_in_d;

  reg_wb_scoreboard u_scoreboard (
    .clk        (clk),
    .reset_n    (reset_n),
    .set_en_i   (ld_issue),
    .set_addr_i (ld_issue_addr),
    .clr_en_i   (grant_c == GNT_LD),
    .clr_addr_i (ld_addr),
    .look_a_i   (rd_addr_a),
    .look_b_i   (rd_addr_b),
    .look_c_i   (alu_addr),
    .pend_a_c_o (pend_a_c),
    .pend_b_c_o (pend_b_c),
    .pend_c_c_o (pend_alu_c)
  );

  // ALU has priority unless it would overtake a pending load or the load has waited MAX_WAIT.
  always_comb begin
    grant_c       = GNT_NONE;
    alu_blocked_c = !is_zero_reg(alu_addr) && pend_alu_c;
    if (alu_valid && !alu_blocked_c) begin
      if (ld_valid && (starve_cnt_q == MAX_WAIT_C)) begin
        grant_c = GNT_LD;
      end else begin
        grant_c = GNT_ALU;
      end
    end else if (ld_valid) begin
      grant_c = GNT_LD;
    end
  end

  assign alu_ready = (grant_c == GNT_ALU);
  assign ld_ready  = (grant_c == GNT_LD);

  always_comb begin
    starve_cnt_d = '0;
    if (ld_valid && (grant_c != GNT_LD)) begin
      starve_cnt_d = (starve_cnt_q == MAX_WAIT_C) ? starve_cnt_q
                                                  : starve_cnt_q + STARVE_W'(1);
    end
  end

  // Address and data hold between grants; only the write strobe drops.
  always_comb begin
    rf_write_d      = 1'b0;
    rf_write_addr_d = rf_write_addr_q;
    rf_data_in_d    = rf_data_in_q;
    unique case (grant_c)
      GNT_ALU: begin
        rf_write_d      = !is_zero_reg(alu_addr);
        rf_write_addr_d = alu_addr;
        rf_data_in_d    = alu_data;
      end
      GNT_LD: begin
        rf_write_d      = !is_zero_reg(ld_addr);
        rf_write_addr_d = ld_addr;
        rf_data_in_d    = ld_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt_q    <= '0;
      rf_write_q      <= 1'b0;
      rf_write_addr_q <= '0;
      rf_data_in_q    <= '0;
    end else begin
      starve_cnt_q    <= starve_cnt_d;
      rf_write_q      <= rf_write_d;
      rf_write_addr_q <= rf_write_addr_d;
      rf_data_in_q    <= rf_data_in_d;
    end
  end

  assign rf_write      = rf_write_q;
  assign rf_write_addr = rf_write_addr_q;
  assign rf_data_in    = rf_data_in_q;

  // A register being written this cycle is still stale for a same-cycle read.
  assign hazard_a = !is_zero_reg(rd_addr_a) &&
                    (pend_a_c || (rf_write_q && (rf_write_addr_q == rd_addr_a)));
  assign hazard_b = !is_zero_reg(rd_addr_b) &&
                    (pend_b_c || (rf_write_q && (rf_write_addr_q == rd_addr_b)));

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Self-checking bench for reg_wb_arbiter: directed vector table, corner
// sequences, and randomized traffic against a behavioural model.
module tb_reg_wb_arbiter;

  localparam int unsigned MAX_WAIT = 3;

  logic        clk;
  logic        reset_n;
  logic        alu_valid;
  logic [4:0]  alu_addr;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        ld_issue;
  logic [4:0]  ld_issue_addr;
  logic        ld_valid;
  logic [4:0]  ld_addr;
  logic [31:0] ld_data;
  logic        ld_ready;
  logic [4:0]  rd_addr_a;
  logic [4:0]  rd_addr_b;
  logic        hazard_a;
  logic        hazard_b;
  logic        rf_write;
  logic [4:0]  rf_write_addr;
  logic [31:0] rf_data_in;

  reg_wb_arbiter #(.MAX_WAIT(MAX_WAIT), .DATA_WIDTH(32)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .alu_valid     (alu_valid),
    .alu_addr      (alu_addr),
    .alu_data      (alu_data),
    .alu_ready     (alu_ready),
    .ld_issue      (ld_issue),
    .ld_issue_addr (ld_issue_addr),
    .ld_valid      (ld_valid),
    .ld_addr       (ld_addr),
    .ld_data       (ld_data),
    .ld_ready      (ld_ready),
    .rd_addr_a     (rd_addr_a),
    .rd_addr_b     (rd_addr_b),
    .hazard_a      (hazard_a),
    .hazard_b      (hazard_b),
    .rf_write      (rf_write),
    .rf_write_addr (rf_write_addr),
    .rf_data_in    (rf_data_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: set of outstanding loads, wait count, write-port registers.
  bit [31:0] m_pend;
  int        m_starve;
  bit        m_wr;
  bit [4:0]  m_waddr;
  bit [31:0] m_wdata;
  bit        m_last_gl;

  typedef struct {
    logic        av;  logic [4:0] aa; logic [31:0] ad;
    logic        iss; logic [4:0] ia;
    logic        lv;  logic [4:0] la; logic [31:0] ldd;
    logic [4:0]  rda;
    logic        e_ar; logic e_lr; logic e_ha;
    logic        e_wr; logic [4:0] e_wa; logic [31:0] e_wd;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_pend = '0; m_starve = 0; m_wr = 1'b0; m_waddr = '0; m_wdata = '0; m_last_gl = 1'b0;
  endfunction

  function automatic bit mhaz(input logic [4:0] a);
    return (a != 5'd0) && (m_pend[a] || (m_wr && (m_waddr == a)));
  endfunction

  function automatic void mgrant(output bit ga, output bit gl);
    bit blk;
    blk = (alu_addr != 5'd0) && m_pend[alu_addr];
    ga = 1'b0;
    gl = 1'b0;
    if (alu_valid && !blk && !(ld_valid && (m_starve == int'(MAX_WAIT)))) ga = 1'b1;
    else if (ld_valid) gl = 1'b1;
  endfunction

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
    ld_issue = 1'b0; ld_issue_addr = '0;
    ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
  endtask

  task automatic check_comb();
    bit ga, gl;
    #1;
    mgrant(ga, gl);
    chk("m_alu_ready", alu_ready, ga);
    chk("m_ld_ready", ld_ready, gl);
    chk("m_hazard_a", hazard_a, mhaz(rd_addr_a));
    chk("m_hazard_b", hazard_b, mhaz(rd_addr_b));
  endtask

  task automatic tick();
    bit ga, gl;
    mgrant(ga, gl);
    @(posedge clk);
    if (gl && ld_addr != 5'd0) m_pend[ld_addr] = 1'b0;
    if (ld_issue && ld_issue_addr != 5'd0) m_pend[ld_issue_addr] = 1'b1;
    if (ld_valid && !gl) m_starve = (m_starve < int'(MAX_WAIT)) ? m_starve + 1 : int'(MAX_WAIT);
    else m_starve = 0;
    if (ga) begin
      m_wr = (alu_addr != 5'd0); m_waddr = alu_addr; m_wdata = alu_data;
    end else if (gl) begin
      m_wr = (ld_addr != 5'd0); m_waddr = ld_addr; m_wdata = ld_data;
    end else begin
      m_wr = 1'b0;
    end
    m_last_gl = gl;
    #1;
    chk("m_rf_write", rf_write, m_wr);
    chk("m_rf_write_addr", rf_write_addr, m_waddr);
    chk("m_rf_data_in", rf_data_in, m_wdata);
  endtask

  task automatic cycle();
    check_comb();
    tick();
  endtask

  initial begin
    // av aa ad | iss ia | lv la ldd | rda | e_ar e_lr e_ha | e_wr e_wa e_wd
    vt.push_back('{1'b1, 5'd5, 32'hAAAA, 1'b0, 5'd0, 1'b1, 5'd6, 32'hBBBB, 5'd0,  1'b1, 1'b0, 1'b0, 1'b1, 5'd5,  32'hAAAA});
    vt.push_back('{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 1'b1, 5'd6, 32'hBBBB, 5'd5,  1'b0, 1'b1, 1'b1, 1'b1, 5'd6,  32'hBBBB});
    vt.push_back('{1'b0, 5'd0, 32'h0,    1'b1, 5'd9, 1'b0, 5'd0, 32'h0,    5'd9,  1'b0, 1'b0, 1'b0, 1'b0, 5'd6,  32'hBBBB});
    vt.push_back('{1'b1, 5'd9, 32'h5555, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,    5'd9,  1'b0, 1'b0, 1'b1, 1'b0, 5'd6,  32'hBBBB});
    vt.push_back('{1'b1, 5'd9, 32'h5555, 1'b0, 5'd0, 1'b1, 5'd9, 32'h1234, 5'd9,  1'b0, 1'b1, 1'b1, 1'b1, 5'd9,  32'h1234});
    vt.push_back('{1'b1, 5'd9, 32'h5555, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,    5'd9,  1'b1, 1'b0, 1'b1, 1'b1, 5'd9,  32'h5555});
    vt.push_back('{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 1'b0, 5'd0, 32'h0,    5'd9,  1'b0, 1'b0, 1'b1, 1'b0, 5'd9,  32'h5555});
    vt.push_back('{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 1'b0, 5'd0, 32'h0,    5'd9,  1'b0, 1'b0, 1'b0, 1'b0, 5'd9,  32'h5555});
    vt.push_back('{1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 1'b0, 5'd0, 32'h0,    5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  32'hDEAD});
    vt.push_back('{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 1'b0, 5'd0, 32'h0,    5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  32'hDEAD});
    vt.push_back('{1'b0, 5'd0, 32'h0,    1'b1, 5'd10,1'b0, 5'd0, 32'h0,    5'd10, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  32'hDEAD});
    vt.push_back('{1'b0, 5'd0, 32'h0,    1'b1, 5'd10,1'b1, 5'd10,32'h77,   5'd10, 1'b0, 1'b1, 1'b1, 1'b1, 5'd10, 32'h77});
    vt.push_back('{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 1'b0, 5'd0, 32'h0,    5'd10, 1'b0, 1'b0, 1'b1, 1'b0, 5'd10, 32'h77});
    vt.push_back('{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 1'b0, 5'd0, 32'h0,    5'd10, 1'b0, 1'b0, 1'b1, 1'b0, 5'd10, 32'h77});
    vt.push_back('{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 1'b1, 5'd10,32'h88,   5'd10, 1'b0, 1'b1, 1'b1, 1'b1, 5'd10, 32'h88});
    vt.push_back('{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 1'b0, 5'd0, 32'h0,    5'd10, 1'b0, 1'b0, 1'b1, 1'b0, 5'd10, 32'h88});
    vt.push_back('{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 1'b0, 5'd0, 32'h0,    5'd10, 1'b0, 1'b0, 1'b0, 1'b0, 5'd10, 32'h88});

    reset_n = 1'b0;
    idle_inputs();
    rd_addr_a = '0; rd_addr_b = '0;
    model_reset();
    #1;
    chk("reset_rf_write", rf_write, 1'b0);
    chk("reset_rf_write_addr", rf_write_addr, 5'd0);
    chk("reset_rf_data_in", rf_data_in, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed vector table: conflict, WAW/hazard, $0, same-cycle set/clear.
    foreach (vt[i]) begin
      alu_valid = vt[i].av; alu_addr = vt[i].aa; alu_data = vt[i].ad;
      ld_issue = vt[i].iss; ld_issue_addr = vt[i].ia;
      ld_valid = vt[i].lv; ld_addr = vt[i].la; ld_data = vt[i].ldd;
      rd_addr_a = vt[i].rda; rd_addr_b = vt[i].rda;
      #1;
      chk($sformatf("tbl%0d_alu_ready", i), alu_ready, vt[i].e_ar);
      chk($sformatf("tbl%0d_ld_ready", i), ld_ready, vt[i].e_lr);
      chk($sformatf("tbl%0d_hazard_a", i), hazard_a, vt[i].e_ha);
      chk($sformatf("tbl%0d_hazard_b", i), hazard_b, vt[i].e_ha);
      check_comb();
      tick();
      chk($sformatf("tbl%0d_rf_write", i), rf_write, vt[i].e_wr);
      chk($sformatf("tbl%0d_rf_write_addr", i), rf_write_addr, vt[i].e_wa);
      chk($sformatf("tbl%0d_rf_data_in", i), rf_data_in, vt[i].e_wd);
    end

    // Starvation: load loses MAX_WAIT cycles, then is forced through.
    rd_addr_a = 5'd8; rd_addr_b = 5'd7;
    for (int k = 0; k < 4; k++) begin
      alu_valid = 1'b1; alu_addr = 5'd7; alu_data = 32'h700 + 32'(k);
      ld_valid = 1'b1; ld_addr = 5'd8; ld_data = 32'h8888;
      #1;
      chk($sformatf("starve%0d_ld_ready", k), ld_ready, (k == 3));
      chk($sformatf("starve%0d_alu_ready", k), alu_ready, (k != 3));
      check_comb();
      tick();
    end
    chk("starve_rf_write_addr", rf_write_addr, 5'd8);
    chk("starve_rf_data_in", rf_data_in, 32'h8888);
    idle_inputs();
    cycle();

    // Randomized traffic; an unaccepted load return is held until it wins.
    for (int c = 0; c < 3000; c++) begin
      alu_valid = ($urandom_range(0, 9) < 7);
      alu_addr = 5'($urandom_range(0, 7));
      alu_data = $urandom;
      ld_issue = ($urandom_range(0, 3) == 0);
      ld_issue_addr = 5'($urandom_range(0, 7));
      if (!(ld_valid && !m_last_gl)) begin
        ld_valid = ($urandom_range(0, 1) == 1);
        ld_addr = 5'($urandom_range(0, 7));
        ld_data = $urandom;
      end
      rd_addr_a = 5'($urandom_range(0, 7));
      rd_addr_b = 5'($urandom_range(0, 7));
      cycle();
    end

    // Asynchronous reset while a write and a pending load are in flight.
    idle_inputs();
    cycle();
    alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'h3333;
    ld_issue = 1'b1; ld_issue_addr = 5'd4;
    rd_addr_a = 5'd4; rd_addr_b = 5'd3;
    cycle();
    ld_issue = 1'b0;
    alu_addr = 5'd12; alu_data = 32'h1212;
    #1;
    chk("prerst_hazard_a", hazard_a, 1'b1);
    chk("prerst_hazard_b", hazard_b, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("rst_rf_write", rf_write, 1'b0);
    chk("rst_rf_write_addr", rf_write_addr, 5'd0);
    chk("rst_rf_data_in", rf_data_in, 32'd0);
    chk("rst_hazard_a", hazard_a, 1'b0);
    chk("rst_hazard_b", hazard_b, 1'b0);
    @(posedge clk);
    #1;
    chk("rst_hold_rf_write", rf_write, 1'b0);
    model_reset();
    idle_inputs();
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1;
    cycle();
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/reg_wb_arbiter.md
Name: reg_wb_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters: execute/ALU results and load-unit results.
- Tracks outstanding load destinations in a scoreboard and flags read hazards on the two read-address lines.
- Stalls ALU writes that would overtake a pending load to the same register.
- Sits between execute/memory stages and the register file; drives the register file's write, write_addr and data_in inputs.

Parameters:
- MAX_WAIT, 3: cycles a valid load may lose arbitration before it is forced to win (1..15).
- DATA_WIDTH, 32: writeback data width.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- alu_valid  in  1  ALU writeback request
- alu_addr  in  5  ALU destination register
- alu_data  in  DATA_WIDTH  ALU result
- alu_ready  out  1  ALU request accepted this cycle
- ld_issue  in  1  load issued to memory; marks destination pending
- ld_issue_addr  in  5  destination of issued load
- ld_valid  in  1  load data return request
- ld_addr  in  5  load destination register
- ld_data  in  DATA_WIDTH  load data
- ld_ready  out  1  load return accepted this cycle
- rd_addr_a  in  5  register file read address A
- rd_addr_b  in  5  register file read address B
- hazard_a  out  1  A's value not yet architecturally valid
- hazard_b  out  1  B's value not yet architecturally valid
- rf_write  out  1  register file write enable (registered)
- rf_write_addr  out  5  register file write address (registered)
- rf_data_in  out  DATA_WIDTH  register file write data (registered)

Behaviour:
- Reset: asserting reset_n low immediately clears the following: pending[31:1]=0, starve_cnt=0, rf_write=0, rf_write_addr=0, rf_data_in=0. Deassertion is sampled on clk. Reset mid-transfer drops any in-flight write.
- Transfer: a request transfers when valid && ready. Ready is combinational from current state and valid inputs. At most one grant per cycle.
- ALU blocked condition: alu_addr!=0 && pending[alu_addr]. This is a WAW order guard; ALU waits until the load writes back.
- Arbitration:
  - Only one eligible requester: it wins.
  - Both valid and ALU not blocked: ALU wins, unless starve_cnt==MAX_WAIT, in which case the load wins.
- starve_cnt: +1 (saturating at MAX_WAIT) each cycle ld_valid && !ld_ready. Clears to 0 on load grant or when ld_valid=0.
- Output stage: on grant, the next clk edge registers rf_write=(addr!=0), rf_write_addr, rf_data_in. Otherwise rf_write=0; addr/data hold.
  - Latency: grant cycle N → register file updated at edge ending cycle N+1.
- Register $0: grants targeting 0 are accepted normally but produce rf_write=0. They never set or clear pending, and never raise hazards.
- Scoreboard:
  - ld_issue with ld_issue_addr!=0 sets pending[addr] at the edge.
  - Load grant clears pending[ld_addr] at the edge.
  - Same-cycle set and clear of the same register: set wins (a new load is outstanding).
  - Issuing to an already-pending register leaves it set; a single return clears it.
- Hazards: hazard_x = (rd_addr_x!=0) && (pending[rd_addr_x] || (rf_write && rf_write_addr==rd_addr_x)). Purely combinational.

Decomposition:
- Package reg_wb_pkg:
  - REG_ADDR_W=5, REG_COUNT=32, ZERO_REG=5'd0.
  - grant_t enum {GNT_NONE, GNT_ALU, GNT_LD}.
  - STARVE_W=4.
- Sub-module reg_wb_scoreboard: pending vector, set/clear priority, and the pending part of hazard lookup on two read ports.
- Top level holds arbitration, the starvation counter and the output register.

Test Plan:
- Reset: hold reset_n=0 mid-grant → rf_write=0, hazards 0, pending cleared asynchronously before next clk.
- Conflict: alu_valid=1 addr 5 data 0xAAAA, ld_valid=1 addr 6 data 0xBBBB (nothing pending) → ALU granted cycle 0, rf_write addr 5/0xAAAA cycle 1; load granted cycle 1, addr 6/0xBBBB cycle 2.
- Starvation: ALU valid every cycle on addr 7, ld_valid held on addr 8, MAX_WAIT=3 → ld_ready=0 for 3 cycles, ld_ready=1 on 4th, alu_ready=0 that cycle.
- WAW/hazard: ld_issue addr 9; rd_addr_a=9 → hazard_a=1 next cycle. ALU valid addr 9 → alu_ready=0 until load returns 0x1234. Register file gets 0x1234, then ALU value on following write. hazard_a drops the cycle after rf_write for addr 9.
- Same-cycle set/clear: load return addr 10 and ld_issue addr 10 in the same cycle → pending[10] stays 1, hazard on 10 persists.
- $0: alu_valid addr 0 and ld_issue addr 0 → alu_ready=1, rf_write=0, no pending set, hazard for rd_addr 0 always 0.
